// File: rtl/warp_result_packer_if.sv
// Write-side bus between the result packer and the host-read FIFO.
//
// Handshake: fifo_wr_en is a registered write strobe; when it is high during a
// cycle, fifo_din is a valid word and the FIFO takes it at the end of that cycle.
// There is no ready signal. The master looks at fifo_almost_full at the edge where
// it decides whether to write, and the write appears one cycle later. The one-entry
// slack between almost_full and full absorbs that one-cycle delay.
interface warp_result_packer_if #(
    parameter int DATA_W = 16
);
    logic                fifo_wr_en;
    logic [2*DATA_W-1:0] fifo_din;
    logic                fifo_almost_full;

    modport master (
        output fifo_wr_en,
        output fifo_din,
        input  fifo_almost_full
    );

    modport slave (
        input  fifo_wr_en,
        input  fifo_din,
        output fifo_almost_full
    );
endinterface

// File: rtl/warp_result_packer.sv
// Transmit-side lane packer. It waits until every kernel lane result is valid and
// snapshots all lanes. It then streams lane pairs as {odd, even} words into the
// host-read FIFO, pausing while almost_full is high, and pulses done in the DONE
// state. LANES must be even and at least 2, and 2**IDX_W must be at least LANES.
module warp_result_packer #(
    parameter int LANES  = 512,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 9
) (
    input  logic                    bus_clk,
    input  logic                    srst,
    input  logic                    start,
    input  logic [LANES*DATA_W-1:0] lane_data,
    input  logic [LANES-1:0]        lane_valid,
    warp_result_packer_if.master    fifo,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        words_sent,
    output logic [1:0]              state_dbg
);

    localparam int               PAIRS    = LANES / 2;
    localparam int               WORD_W   = 2 * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic              all_valid;
    logic              send_fire;

    // Each entry holds one lane pair, stored already packed: odd lane high, even lane low.
    logic [WORD_W-1:0] snap [PAIRS];

    assign all_valid = &lane_valid;
    assign send_fire = (state == ST_SEND) && !fifo.fifo_almost_full;

    // State register.
    always_ff @(posedge bus_clk) begin
        if (srst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision; start is only honoured from IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)                          state_next = ST_WAIT;
            ST_WAIT: if (all_valid)                      state_next = ST_SEND;
            ST_SEND: if (send_fire && idx == LAST_IDX)   state_next = ST_DONE;
            ST_DONE:                                     state_next = ST_IDLE;
            default:                                     state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        state_dbg = state;
    end

    // Snapshot all lanes on the edge that leaves WAIT; later input changes are ignored.
    always_ff @(posedge bus_clk) begin
        if (state == ST_WAIT && all_valid) begin
            for (int p = 0; p < PAIRS; p++) begin
                snap[p] <= lane_data[p*WORD_W +: WORD_W];
            end
        end
    end

    // Write path: register the strobe and word, and advance the lane index and word count.
    always_ff @(posedge bus_clk) begin
        if (srst) begin
            idx             <= '0;
            words_sent      <= '0;
            fifo.fifo_wr_en <= 1'b0;
            fifo.fifo_din   <= '0;
        end else begin
            fifo.fifo_wr_en <= send_fire;
            if (state == ST_IDLE && start) begin
                idx        <= '0;
                words_sent <= '0;
            end
            if (send_fire) begin
                fifo.fifo_din <= snap[idx[IDX_W-1:1]];
                idx           <= idx + IDX_W'(2);
                words_sent    <= words_sent + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_warp_result_packer.sv
// Bench for warp_result_packer. Expected words are queued when a result set is
// presented, and they are popped and compared as the FIFO write strobe fires.
module tb_warp_result_packer;

    localparam int LANES  = 512;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 9;
    localparam int WORDS  = LANES / 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    srst;
    logic                    start;
    logic [LANES*DATA_W-1:0] lane_data;
    logic [LANES-1:0]        lane_valid;
    logic                    busy;
    logic                    done;
    logic [IDX_W-1:0]        words_sent;
    logic [1:0]              state_dbg;

    warp_result_packer_if #(.DATA_W(DATA_W)) fifo_bus ();

    warp_result_packer #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) dut (
        .bus_clk   (clk),
        .srst      (srst),
        .start     (start),
        .lane_data (lane_data),
        .lane_valid(lane_valid),
        .fifo      (fifo_bus.master),
        .busy      (busy),
        .done      (done),
        .words_sent(words_sent),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [2*DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int wr_total = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe consumes one expected word.
    always @(negedge clk) begin
        if (fifo_bus.fifo_wr_en === 1'b1) begin
            logic [2*DATA_W-1:0] exp_w;
            wr_total++;
            if (exp_q.size() == 0) begin
                check_eq("extra_wr", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_w = exp_q.pop_front();
                check_eq("word", fifo_bus.fifo_din, exp_w);
            end
        end
    end

    // almost_full driver: when enabled, high on one cycle out of every three.
    int   af_phase = 0;
    logic af_mode  = 1'b0;
    initial fifo_bus.fifo_almost_full = 1'b0;
    always @(posedge clk) begin
        #1;
        af_phase = (af_phase == 2) ? 0 : af_phase + 1;
        fifo_bus.fifo_almost_full = af_mode && (af_phase == 0);
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_lanes(input logic [15:0] base);
        for (int i = 0; i < LANES; i++) begin
            lane_data[i*DATA_W +: DATA_W] = base + 16'(i);
        end
    endtask

    task automatic push_expected(input logic [15:0] base);
        for (int p = 0; p < WORDS; p++) begin
            exp_q.push_back({base + 16'(2*p + 1), base + 16'(2*p)});
        end
    endtask

    task automatic wait_first_write(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (fifo_bus.fifo_wr_en !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(n), 32'(exp_lat));
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int k;
        int wr0;
        int bad_wr;
        int not_busy;

        srst       = 1'b1;
        start      = 1'b0;
        lane_data  = '0;
        lane_valid = '0;
        repeat (3) tick();
        check_eq("rst_wr_en", 32'(fifo_bus.fifo_wr_en), 32'd0);
        check_eq("rst_din", fifo_bus.fifo_din, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_words", 32'(words_sent), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        srst = 1'b0;
        tick();

        // T1: full unstalled set
        load_lanes(16'hA000);
        lane_valid = '1;
        push_expected(16'hA000);
        wr0 = wr_total;
        start_pulse();
        wait_first_write("t1_first_lat", 2);
        check_eq("t1_word0", fifo_bus.fifo_din, 32'hA001A000);
        wait_done("t1_done", 400, n);
        check_eq("t1_run_len", 32'(n), 32'd255);
        check_eq("t1_wr_at_done", 32'(fifo_bus.fifo_wr_en), 32'd1);
        check_eq("t1_last_word", fifo_bus.fifo_din, 32'hA1FFA1FE);
        check_eq("t1_words_sent", 32'(words_sent), 32'd256);
        tick();
        check_eq("t1_done_pulse", 32'(done), 32'd0);
        check_eq("t1_idle_busy", 32'(busy), 32'd0);
        check_eq("t1_words_hold", 32'(words_sent), 32'd256);
        check_eq("t1_writes", 32'(wr_total - wr0), 32'd256);

        // T2: one lane not valid for 50 cycles
        load_lanes(16'hB000);
        lane_valid      = '1;
        lane_valid[511] = 1'b0;
        push_expected(16'hB000);
        wr0 = wr_total;
        start_pulse();
        bad_wr   = 0;
        not_busy = 0;
        repeat (50) begin
            tick();
            if (fifo_bus.fifo_wr_en !== 1'b0) bad_wr++;
            if (busy !== 1'b1) not_busy++;
        end
        check_eq("t2_no_wr", 32'(bad_wr), 32'd0);
        check_eq("t2_busy", 32'(not_busy), 32'd0);
        lane_valid[511] = 1'b1;
        wait_first_write("t2_first_lat", 2);
        wait_done("t2_done", 400, n);
        tick();
        check_eq("t2_writes", 32'(wr_total - wr0), 32'd256);

        // T3: almost_full one cycle in three
        af_mode = 1'b1;
        load_lanes(16'hC000);
        push_expected(16'hC000);
        wr0 = wr_total;
        start_pulse();
        wait_done("t3_done", 1000, n);
        check_eq("t3_stalled", 32'(n > 255), 32'd1);
        check_eq("t3_words_sent", 32'(words_sent), 32'd256);
        tick();
        af_mode = 1'b0;
        check_eq("t3_writes", 32'(wr_total - wr0), 32'd256);

        // T4: inputs cleared right after the snapshot edge
        load_lanes(16'hD000);
        lane_valid = '1;
        push_expected(16'hD000);
        wr0 = wr_total;
        start_pulse();
        tick();
        lane_data  = '0;
        lane_valid = '0;
        wait_done("t4_done", 400, n);
        tick();
        check_eq("t4_writes", 32'(wr_total - wr0), 32'd256);
        lane_valid = '1;

        // T5: reset partway through a set, then a clean set
        load_lanes(16'hE000);
        push_expected(16'hE000);
        wr0 = wr_total;
        start_pulse();
        k = 0;
        while (wr_total - wr0 < 100 && k < 500) begin
            tick();
            k++;
        end
        check_eq("t5_reached_100", 32'(wr_total - wr0 >= 100), 32'd1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check_eq("t5_wr_en", 32'(fifo_bus.fifo_wr_en), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_words", 32'(words_sent), 32'd0);
        check_eq("t5_state", 32'(state_dbg), 32'd0);
        exp_q.delete();
        load_lanes(16'hF000);
        push_expected(16'hF000);
        wr0 = wr_total;
        start_pulse();
        wait_done("t5_done", 400, n);
        tick();
        check_eq("t5_writes", 32'(wr_total - wr0), 32'd256);

        // T6: start held high across a whole set
        load_lanes(16'h1000);
        push_expected(16'h1000);
        push_expected(16'h1000);
        wr0   = wr_total;
        start = 1'b1;
        tick();
        tick();
        wait_done("t6a_done", 400, n);
        check_eq("t6a_words_sent", 32'(words_sent), 32'd256);
        tick();
        check_eq("t6a_writes", 32'(wr_total - wr0), 32'd256);
        check_eq("t6_idle_busy", 32'(busy), 32'd0);
        tick();
        check_eq("t6_restart_state", 32'(state_dbg), 32'd1);
        start = 1'b0;
        wait_done("t6b_done", 400, n);
        tick();
        check_eq("t6b_writes", 32'(wr_total - wr0), 32'd512);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
